shift_pipe: RTL and testbench

- Parametrised, pipelined barrel-shift unit for the ALU datapath; next generation of the single-mode combinational left shifter.
- Adds width generalisation, five shift/rotate modes, per-stage pipeline registers and a valid/ready handshake with backpressure.
- Sits between operand decode and result writeback.
- One transaction per cycle at full throughput.

---
 rtl/shift_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_shift_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// -----------------------------------------------------------------------------
// shift_pipe
//
// Pipelined barrel shifter / rotator for the ALU datapath. The shift amount is
// decomposed into SHW mux layers. Layer i moves the word by 2^i positions when
// in_shamt[i] is set. Layers are grouped into L = ceil(SHW/REG_EVERY) register
// stages. The last stage is also the output holding register.
//
// Supported operations (in_op):
//   000 SLL  logical left, zero fill
//   001 SRL  logical right, zero fill
//   010 SRA  arithmetic right, fill with the operand MSB captured at issue
//   011 ROL  rotate left
//   100 ROR  rotate right
//   others   illegal: the operand passes through unchanged and out_err=1
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand valid
//   in_ready   unit can accept this cycle (combinational from the output side)
//   in_data    operand, WIDTH bits
//   in_shamt   shift amount, SHW bits
//   in_op      operation code, 3 bits
//   out_valid  result valid (last-stage valid bit)
//   out_ready  consumer accepts the result
//   out_data   result, WIDTH bits
//   out_zero   out_data == 0, registered alongside out_data
//   out_err    the result came from an illegal in_op
//
// Handshake: a word moves in on a clock edge where in_valid && in_ready, and
// moves out on an edge where out_valid && out_ready. Every stage register
// loads only when advance = !out_valid || out_ready, so the whole pipeline
// stalls together. in_ready equals advance and never depends on in_valid.
// Bubbles are carried through as valid=0 slots and are not squeezed out.
// -----------------------------------------------------------------------------
module shift_pipe #(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 1,
    localparam int SHW      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_err
);

    // Number of register stages (pipeline latency in cycles).
    localparam int L = (SHW + REG_EVERY - 1) / REG_EVERY;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    // Control information that travels alongside the data word.
    // sign is the operand MSB sampled at issue; SRA fills with it in every
    // later layer.
    typedef struct packed {
        logic [2:0]     op;
        logic [SHW-1:0] shamt;
        logic           sign;
    } meta_t;

    // -------------------------------------------------------------------------
    // Stage registers. Index k (1..L) is the register after stage k's group of
    // mux layers. Stage L drives the outputs.
    // -------------------------------------------------------------------------
    logic [L:1]       valid_q, valid_d;
    logic [WIDTH-1:0] data_q [1:L];
    logic [WIDTH-1:0] data_d [1:L];
    meta_t            meta_q [1:L];
    meta_t            meta_d [1:L];
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic             advance;

    // One mux layer: move the word by sh positions (sh is a power of two and
    // is always below WIDTH, so the WIDTH-sh rotate term never reaches WIDTH).
    function automatic logic [WIDTH-1:0] layer_shift(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       op,
        input logic             sign,
        input int               sh
    );
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] r;
        ones = '1;
        case (op)
            OP_SLL:  r = d << sh;
            OP_SRL:  r = d >> sh;
            // The top sh bits are vacated by the right shift; ~(ones >> sh)
            // selects exactly those positions.
            OP_SRA:  r = (d >> sh) | (sign ? ~(ones >> sh) : '0);
            OP_ROL:  r = (d << sh) | (d >> (WIDTH - sh));
            OP_ROR:  r = (d >> sh) | (d << (WIDTH - sh));
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic op_illegal(input logic [2:0] op);
        return (op > OP_ROR);
    endfunction

    // -------------------------------------------------------------------------
    // Next-state logic for every stage.
    // -------------------------------------------------------------------------
    always_comb begin : stage_logic
        logic [WIDTH-1:0] cur;
        meta_t            src_meta;
        logic             src_valid;

        advance = !valid_q[L] || out_ready;

        valid_d = valid_q;
        zero_d  = zero_q;
        err_d   = err_q;
        for (int k = 1; k <= L; k++) begin
            data_d[k] = data_q[k];
            meta_d[k] = meta_q[k];
        end

        cur       = '0;
        src_meta  = '0;
        src_valid = 1'b0;

        for (int k = 1; k <= L; k++) begin
            if (k == 1) begin
                cur            = in_data;
                src_meta.op    = in_op;
                src_meta.shamt = in_shamt;
                src_meta.sign  = in_data[WIDTH-1];
                src_valid      = in_valid;
            end else begin
                cur       = data_q[k-1];
                src_meta  = meta_q[k-1];
                src_valid = valid_q[k-1];
            end

            // Apply the mux layers that belong to stage k.
            for (int i = 0; i < SHW; i++) begin
                if ((i / REG_EVERY) == (k - 1) && src_meta.shamt[i]) begin
                    cur = layer_shift(cur, src_meta.op, src_meta.sign, 1 << i);
                end
            end

            if (advance) begin
                valid_d[k] = src_valid;
                data_d[k]  = cur;
                meta_d[k]  = src_meta;
            end
        end

        // The flags are registered together with the final data word so that
        // they hold with it during a stall.
        if (advance) begin
            zero_d = (data_d[L] == '0);
            err_d  = op_illegal(meta_d[L].op);
        end
    end

    // -------------------------------------------------------------------------
    // State registers. The async reset clears every valid bit, which discards
    // anything in flight.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 1; k <= L; k++) begin
                data_q[k] <= '0;
                meta_q[k] <= '0;
            end
            zero_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            for (int k = 1; k <= L; k++) begin
                data_q[k] <= data_d[k];
                meta_q[k] <= meta_d[k];
            end
            zero_q <= zero_d;
            err_q  <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready  = advance;
    assign out_valid = valid_q[L];
    assign out_data  = data_q[L];
    assign out_zero  = zero_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_shift_pipe.sv
// -----------------------------------------------------------------------------
// tb_shift_pipe
//
// Three instances of shift_pipe: (WIDTH=32, REG_EVERY=1), (8, 2) and (64, 3).
// Each instance has its own scoreboard. Expected results come from a
// whole-amount reference shift on 64-bit arithmetic. The 32-bit instance also
// gets the directed scenarios: single issue, back-to-back mixed ops, zero and
// illegal cases, a backpressure window and a reset with work in flight.
// -----------------------------------------------------------------------------
module tb_shift_pipe;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic clk = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mark_done();
        done_cnt++;
    endtask

    // Reference: apply the whole shift amount in one step on a w-bit word.
    function automatic logic [63:0] ref_shift(input logic [63:0] d_in, input int op,
                                              input int s, input int w);
        logic [63:0] mask;
        logic [63:0] d;
        logic [63:0] r;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        d    = d_in & mask;
        case (op)
            0: r = (d << s) & mask;
            1: r = d >> s;
            2: begin
                r = d >> s;
                if (d[w-1]) r = r | (mask & ~(mask >> s));
            end
            3: r = (s == 0) ? d : (((d << s) | (d >> (w - s))) & mask);
            4: r = (s == 0) ? d : (((d >> s) | (d << (w - s))) & mask);
            default: r = d;
        endcase
        return r;
    endfunction

    // Hand-computed values that pin the reference model.
    initial begin
        check_eq("model_sll31",   ref_shift(64'h1, 0, 31, 32),          64'h8000_0000);
        check_eq("model_sra4",    ref_shift(64'h8000_0000, 2, 4, 32),   64'hF800_0000);
        check_eq("model_srl4",    ref_shift(64'h8000_0000, 1, 4, 32),   64'h0800_0000);
        check_eq("model_ror4",    ref_shift(64'h0000_00F1, 4, 4, 32),   64'h1000_000F);
        check_eq("model_rol4",    ref_shift(64'hF000_0001, 3, 4, 32),   64'h0000_001F);
        check_eq("model_srl1",    ref_shift(64'h1, 1, 1, 32),           64'h0);
        check_eq("model_illegal", ref_shift(64'h1234_5678, 7, 3, 32),   64'h1234_5678);
        check_eq("model_sra8",    ref_shift(64'h80, 2, 3, 8),           64'hF0);
        check_eq("model_rol64",   ref_shift(64'h8000_0000_0000_0001, 3, 1, 64), 64'h3);
    end

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int W   = (g == 0) ? 32 : ((g == 1) ? 8 : 64);
        localparam int R   = (g == 0) ? 1 : ((g == 1) ? 2 : 3);
        localparam int SW  = $clog2(W);
        localparam int LAT = (SW + R - 1) / R;

        logic          rst_n;
        logic          in_valid;
        logic          in_ready;
        logic [W-1:0]  in_data;
        logic [SW-1:0] in_shamt;
        logic [2:0]    in_op;
        logic          out_valid;
        logic          out_ready;
        logic [W-1:0]  out_data;
        logic          out_zero;
        logic          out_err;

        shift_pipe #(.WIDTH(W), .REG_EVERY(R)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .in_data  (in_data),
            .in_shamt (in_shamt),
            .in_op    (in_op),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .out_data (out_data),
            .out_zero (out_zero),
            .out_err  (out_err)
        );

        // Scoreboard
        logic [W-1:0] exp_q[$];
        bit           exp_err_q[$];
        int           acc_cyc_q[$];
        int           acc_stall_q[$];
        int           stall_cnt = 0;
        bit           seen = 1'b0;
        bit           held = 1'b0;
        logic [W-1:0] held_data;
        logic         held_zero;
        logic         held_err;

        // Compare process: sampled on the falling edge, so every value seen
        // here is what the next rising edge will act on.
        initial begin : compare
            logic [63:0] m;
            forever begin
                @(negedge clk);
                if (rst_n !== 1'b1) begin
                    exp_q.delete();
                    exp_err_q.delete();
                    acc_cyc_q.delete();
                    acc_stall_q.delete();
                    seen = 1'b0;
                    held = 1'b0;
                end else begin
                    check_eq($sformatf("w%0d_in_ready", W), in_ready, !out_valid || out_ready);
                    if (held) begin
                        check_eq($sformatf("w%0d_hold_valid", W), out_valid, 1'b1);
                        check_eq($sformatf("w%0d_hold_data", W), out_data, held_data);
                        check_eq($sformatf("w%0d_hold_zero", W), out_zero, held_zero);
                        check_eq($sformatf("w%0d_hold_err", W), out_err, held_err);
                    end
                    if (out_valid === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            check_eq($sformatf("w%0d_unexpected_out", W), out_valid, 1'b0);
                        end else begin
                            if (!seen) begin
                                check_eq($sformatf("w%0d_latency", W), cyc - acc_cyc_q[0],
                                         LAT + stall_cnt - acc_stall_q[0]);
                                seen = 1'b1;
                            end
                            if (out_ready) begin
                                check_eq($sformatf("w%0d_data", W), out_data, exp_q[0]);
                                check_eq($sformatf("w%0d_zero", W), out_zero, exp_q[0] == '0);
                                check_eq($sformatf("w%0d_err", W), out_err, exp_err_q[0]);
                                void'(exp_q.pop_front());
                                void'(exp_err_q.pop_front());
                                void'(acc_cyc_q.pop_front());
                                void'(acc_stall_q.pop_front());
                                seen = 1'b0;
                            end
                        end
                    end
                    if (in_valid && in_ready) begin
                        m = ref_shift(64'(in_data), int'(in_op), int'(in_shamt), W);
                        exp_q.push_back(m[W-1:0]);
                        exp_err_q.push_back(in_op > 3'd4);
                        acc_cyc_q.push_back(cyc);
                        acc_stall_q.push_back(stall_cnt);
                    end
                    if (out_valid && !out_ready) begin
                        stall_cnt++;
                        held      = 1'b1;
                        held_data = out_data;
                        held_zero = out_zero;
                        held_err  = out_err;
                    end else begin
                        held = 1'b0;
                    end
                end
            end
        end

        // Driver tasks
        task automatic issue(input logic [W-1:0] d, input logic [2:0] op,
                             input logic [SW-1:0] s, input bit rnd);
            bit acc;
            int guard;
            acc      = 1'b0;
            guard    = 0;
            in_valid = 1'b1;
            in_data  = d;
            in_op    = op;
            in_shamt = s;
            while (!acc && guard < 200) begin
                @(negedge clk);
                acc = (in_ready === 1'b1);
                @(posedge clk);
                #1;
                if (rnd) out_ready = ($urandom_range(0, 3) != 0);
                guard++;
            end
            in_valid = 1'b0;
            if (!acc) check_eq($sformatf("w%0d_issue_timeout", W), 0, 1);
        endtask

        task automatic wait_drain();
            int guard;
            guard = 0;
            while ((exp_q.size() != 0 || out_valid) && guard < 500) begin
                @(posedge clk);
                #1;
                guard++;
            end
            if (guard >= 500) check_eq($sformatf("w%0d_drain_timeout", W), exp_q.size(), 0);
        endtask

        task automatic rand_run(input int n);
            logic [63:0] r;
            logic [2:0]  op;
            int          s;
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                r  = {$urandom(), $urandom()};
                op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                                 : 3'($urandom_range(0, 4));
                case ($urandom_range(0, 5))
                    0:       s = 0;
                    1:       s = W - 1;
                    default: s = $urandom_range(0, W - 1);
                endcase
                issue(r[W-1:0], op, SW'(s), 1'b1);
            end
            out_ready = 1'b1;
            wait_drain();
        endtask

        if (g == 0) begin : directed
            initial begin
                logic [63:0] r;
                rst_n     = 1'b0;
                in_valid  = 1'b0;
                in_data   = '0;
                in_shamt  = '0;
                in_op     = '0;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                check_eq("w32_rst_out_valid", out_valid, 1'b0);
                check_eq("w32_rst_out_data", out_data, '0);
                check_eq("w32_rst_out_zero", out_zero, 1'b0);
                check_eq("w32_rst_out_err", out_err, 1'b0);
                check_eq("w32_rst_in_ready", in_ready, 1'b1);
                rst_n     = 1'b1;
                out_ready = 1'b1;

                // Single issue.
                issue(32'h0000_0001, 3'b000, 5'd31, 1'b0);
                wait_drain();

                // Back-to-back mixed operations.
                issue(32'h8000_0000, 3'b010, 5'd4, 1'b0);
                issue(32'h8000_0000, 3'b001, 5'd4, 1'b0);
                issue(32'h0000_00F1, 3'b100, 5'd4, 1'b0);
                issue(32'hF000_0001, 3'b011, 5'd4, 1'b0);
                wait_drain();

                // Shift by zero, a zero result, an illegal op, then a legal op.
                issue(32'hFFFF_FFFF, 3'b000, 5'd0, 1'b0);
                issue(32'h0000_0001, 3'b001, 5'd1, 1'b0);
                issue(32'h1234_5678, 3'b111, 5'd7, 1'b0);
                issue(32'h0000_00F0, 3'b001, 5'd4, 1'b0);
                wait_drain();

                // Backpressure window while streaming eight random operations.
                fork
                    begin
                        for (int i = 0; i < 8; i++) begin
                            r = {$urandom(), $urandom()};
                            issue(r[31:0], 3'($urandom_range(0, 4)), 5'($urandom_range(0, 31)), 1'b0);
                        end
                    end
                    begin
                        repeat (3) @(posedge clk);
                        #1;
                        out_ready = 1'b0;
                        repeat (8) @(posedge clk);
                        #1;
                        out_ready = 1'b1;
                    end
                join
                wait_drain();

                // Reset with three transactions in flight.
                issue(32'h0000_0011, 3'b000, 5'd1, 1'b0);
                issue(32'h0000_0022, 3'b011, 5'd2, 1'b0);
                issue(32'h0000_0033, 3'b100, 5'd3, 1'b0);
                rst_n = 1'b0;
                #1;
                check_eq("w32_midrst_out_valid", out_valid, 1'b0);
                check_eq("w32_midrst_out_data", out_data, '0);
                check_eq("w32_midrst_in_ready", in_ready, 1'b1);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                repeat (12) @(posedge clk);
                #1;
                issue(32'hA5A5_0F0F, 3'b010, 5'd8, 1'b0);
                wait_drain();

                rand_run(200);
                mark_done();
            end
        end else begin : random_only
            initial begin
                rst_n     = 1'b0;
                in_valid  = 1'b0;
                in_data   = '0;
                in_shamt  = '0;
                in_op     = '0;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                check_eq($sformatf("w%0d_rst_out_valid", W), out_valid, 1'b0);
                rst_n     = 1'b1;
                out_ready = 1'b1;
                rand_run(300);
                mark_done();
            end
        end
    end

    initial begin
        fork
            begin
                wait (done_cnt == 3);
            end
            begin
                #400000;
            end
        join_any
        if (done_cnt != 3) check_eq("global_timeout", done_cnt, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
